ram_port_arbiter: RTL

//  Upstream feeder for the io881 RAM. Two requesters, port 0 (instruction fetch) and

---
 rtl/ram_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter feeding one RAM from two req/ack ports.
// The winning transaction becomes registered a/d/wr/rd strobes, and read data is captured after READ_LAT.
module ram_port_arbiter #(
  parameter int DATA_    = 8,
  parameter int ADDR_    = 15,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [ADDR_-1:0] p0_addr,
  input  logic [DATA_-1:0] p0_wdata,
  output logic             p0_ack,
  output logic [DATA_-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [ADDR_-1:0] p1_addr,
  input  logic [DATA_-1:0] p1_wdata,
  output logic             p1_ack,
  output logic [DATA_-1:0] p1_rdata,
  output logic [ADDR_-1:0] a,
  output logic [DATA_-1:0] d,
  output logic             wr,
  output logic             rd,
  input  logic [DATA_-1:0] q,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t           state, state_n;
  logic             gnt, gnt_n;
  logic             we_r, we_n;
  logic             rr_last, rr_n;
  logic [ADDR_-1:0] a_n;
  logic [DATA_-1:0] d_n, r0_n, r1_n;
  logic             wr_n, rd_n;
  logic [1:0]       cnt, cnt_n;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    we_n    = we_r;
    rr_n    = rr_last;
    a_n     = a;
    d_n     = d;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    cnt_n   = cnt;
    r0_n    = p0_rdata;
    r1_n    = p1_rdata;
    p0_ack  = 1'b0;
    p1_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          // rr_last only moves on a genuine tie; a lone requester leaves it alone
          if (p0_req && p1_req) begin
            gnt_n = ~rr_last;
            rr_n  = ~rr_last;
          end else begin
            gnt_n = p1_req;
          end
          we_n    = gnt_n ? p1_we   : p0_we;
          a_n     = gnt_n ? p1_addr : p0_addr;
          d_n     = we_n ? (gnt_n ? p1_wdata : p0_wdata) : '0;
          wr_n    = we_n;
          rd_n    = ~we_n;
          state_n = ISSUE;
        end else begin
          a_n = '0;
          d_n = '0;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_n = ACK;
        end else begin
          cnt_n   = 2'(READ_LAT - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          if (gnt) r1_n = q;
          else     r0_n = q;
          state_n = ACK;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      ACK: begin
        p0_ack  = ~gnt;
        p1_ack  = gnt;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      we_r     <= 1'b0;
      rr_last  <= 1'b1;
      a        <= '0;
      d        <= '0;
      wr       <= 1'b0;
      rd       <= 1'b0;
      cnt      <= '0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      we_r     <= we_n;
      rr_last  <= rr_n;
      a        <= a_n;
      d        <= d_n;
      wr       <= wr_n;
      rd       <= rd_n;
      cnt      <= cnt_n;
      p0_rdata <= r0_n;
      p1_rdata <= r1_n;
    end
  end

endmodule
